// File: rtl/sdram_device_model.sv
// SDRAM device responder: decodes pin-level commands, tracks four banks,
// stores 32-bit words, returns read data after CAS latency and records
// protocol/timing violations made by the initiator.
module sdram_device_model #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8,
    parameter int CAS_LAT  = 3,
    parameter int TRCD     = 3,
    parameter int TRP      = 3,
    parameter int TRFC     = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cle,
    input  logic        sdram_cs,
    input  logic        sdram_ras,
    input  logic        sdram_cas,
    input  logic        sdram_we,
    input  logic        sdram_dqm,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic [31:0] sdram_dqo,
    output logic [31:0] sdram_dqi,
    output logic        err_flag,
    output logic [2:0]  err_code,
    output logic [7:0]  err_count,
    output logic [3:0]  bank_open
);

    localparam int T_MAX = (TRFC > TRCD) ? ((TRFC > TRP) ? TRFC : TRP)
                                         : ((TRCD > TRP) ? TRCD : TRP);
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRCD_C  = CNT_W'(TRCD);
    localparam logic [CNT_W-1:0] TRP_C   = CNT_W'(TRP);
    localparam logic [CNT_W-1:0] TRFC_C  = CNT_W'(TRFC);

    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    // Counters hold "edges elapsed since the event", saturating at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic [3:0]             open_q, open_d;
    logic [3:0][12:0]       row_q, row_d;
    logic [3:0][CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [CNT_W-1:0]       rfc_q, rfc_d;
    logic [CAS_LAT-1:0]     pv_q;
    logic [CAS_LAT-1:0][31:0] pd_q;
    logic [31:0]            dqi_q;
    logic                   err_flag_q;
    logic [2:0]             err_code_q;
    logic [7:0]             err_count_q;

    logic [3:0]             cmd_s;
    logic                   viol_s;
    logic [2:0]             vcode_s;
    logic                   wr_s;
    logic                   rd_s;
    logic [IDX_W-1:0]       idx_s;
    logic [31:0]            rd_word_s;
    logic [31:0]            mem [DEPTH];

    assign cmd_s     = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
    assign idx_s     = {sdram_ba, row_q[sdram_ba][ROW_BITS-1:0], sdram_a[COL_BITS+1:2]};
    assign rd_word_s = mem[idx_s];

    // Command decode, legality checks and next bank/timer state.
    always_comb begin
        open_d  = open_q;
        row_d   = row_q;
        rfc_d   = sat_inc(rfc_q);
        viol_s  = 1'b0;
        vcode_s = 3'd0;
        wr_s    = 1'b0;
        rd_s    = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bcnt_d[b] = sat_inc(bcnt_q[b]);
        end
        if (sdram_cs == 1'b0 && cmd_s != CMD_NOP) begin
            if (rfc_q < TRFC_C) begin
                viol_s  = 1'b1;
                vcode_s = 3'd6;
            end else begin
                case (cmd_s)
                    CMD_ACT: begin
                        if (open_q[sdram_ba]) begin
                            viol_s  = 1'b1;
                            vcode_s = 3'd2;
                        end else if (bcnt_q[sdram_ba] < TRP_C) begin
                            viol_s  = 1'b1;
                            vcode_s = 3'd4;
                        end else begin
                            open_d[sdram_ba] = 1'b1;
                            row_d[sdram_ba]  = sdram_a;
                            bcnt_d[sdram_ba] = CNT_ONE;
                        end
                    end
                    CMD_RD, CMD_WR: begin
                        if (!open_q[sdram_ba]) begin
                            viol_s  = 1'b1;
                            vcode_s = 3'd1;
                        end else if (bcnt_q[sdram_ba] < TRCD_C) begin
                            viol_s  = 1'b1;
                            vcode_s = 3'd3;
                        end else begin
                            rd_s = (cmd_s == CMD_RD);
                            wr_s = (cmd_s == CMD_WR) && !sdram_dqm;
                            if (sdram_a[10]) begin
                                // auto-precharge: TRP starts at this edge
                                open_d[sdram_ba] = 1'b0;
                                bcnt_d[sdram_ba] = CNT_ONE;
                            end else begin
                                open_d[sdram_ba] = open_q[sdram_ba];
                            end
                        end
                    end
                    CMD_PRE: begin
                        for (int b = 0; b < 4; b++) begin
                            // closed banks keep their counter running
                            if ((sdram_a[10] || sdram_ba == b[1:0]) && open_q[b]) begin
                                open_d[b] = 1'b0;
                                bcnt_d[b] = CNT_ONE;
                            end else begin
                                open_d[b] = open_q[b];
                            end
                        end
                    end
                    CMD_REF: begin
                        if (|open_q) begin
                            viol_s  = 1'b1;
                            vcode_s = 3'd5;
                        end else begin
                            rfc_d = CNT_ONE;
                        end
                    end
                    default: begin
                        // LOAD_MODE and TERMINATE: accepted, no effect
                        viol_s = 1'b0;
                    end
                endcase
            end
        end else begin
            viol_s = 1'b0;
        end
    end

    // Bank state, timers, read pipeline and error registers; frozen while cle=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q      <= 4'b0000;
            row_q       <= '0;
            bcnt_q      <= {4{CNT_MAX}};
            rfc_q       <= CNT_MAX;
            pv_q        <= '0;
            pd_q        <= '0;
            dqi_q       <= 32'h0000_0000;
            err_flag_q  <= 1'b0;
            err_code_q  <= 3'd0;
            err_count_q <= 8'd0;
        end else if (sdram_cle) begin
            open_q <= open_d;
            row_q  <= row_d;
            bcnt_q <= bcnt_d;
            rfc_q  <= rfc_d;
            pv_q   <= {pv_q[CAS_LAT-2:0], rd_s};
            pd_q   <= {pd_q[CAS_LAT-2:0], rd_word_s};
            if (pv_q[CAS_LAT-1]) begin
                dqi_q <= pd_q[CAS_LAT-1];
            end
            if (viol_s) begin
                if (err_count_q != 8'hFF) begin
                    err_count_q <= err_count_q + 8'd1;
                end
                if (!err_flag_q) begin
                    err_flag_q <= 1'b1;
                    err_code_q <= vcode_s;
                end
            end
        end
    end

    // Word storage, written on the WRITE edge so a following READ sees it.
    always_ff @(posedge clk) begin
        if (sdram_cle && wr_s) begin
            mem[idx_s] <= sdram_dqo;
        end
    end

    assign sdram_dqi = dqi_q;
    assign err_flag  = err_flag_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
    assign bank_open = open_q;

endmodule
